// File: rtl/arbitrated_memory_controller.sv
// Boots the shared RAM from a fixed ROM image, then serves NUM_PORTS requesters
// through a round-robin arbiter with 1-cycle read responses and range checking.

module amc_port_decode #(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_WORDS  = 2**ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range
);
  // One extra bit so MEM_WORDS == 2**ADDR_WIDTH compares correctly
  assign in_range = {1'b0, addr} < (ADDR_WIDTH+1)'(MEM_WORDS);
endmodule

module arbitrated_memory_controller #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PORTS   = 2,
  parameter int MEM_WORDS   = 2**ADDR_WIDTH,
  parameter int BOOT_WORDS  = MEM_WORDS,
  parameter int BYPASS_BOOT = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            boot_done,
  output logic                            memory_error,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_error
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BOOT_LAST = ADDR_WIDTH'(BOOT_WORDS - 1);

  typedef enum logic [2:0] {
    BOOT_FETCH = 3'd0,
    BOOT_WRITE = 3'd1,
    RUNNING    = 3'd2,
    ERROR      = 3'd4
  } state_t;

  typedef struct packed {
    logic                  write;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                                state, state_n;
  logic [ADDR_WIDTH-1:0]                 boot_addr;
  logic [PW-1:0]                         rr;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_a;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_a;
  logic [NUM_PORTS-1:0]                  in_range;
  logic [PW-1:0]                         grant, idx;
  logic                                  grant_vld, hs;
  req_t                                  g;
  logic [DATA_WIDTH-1:0]                 rom_q, ram_q;
  logic [DATA_WIDTH-1:0]                 mem [2**ADDR_WIDTH];
  logic                                  ram_we;
  logic [ADDR_WIDTH-1:0]                 ram_waddr;
  logic [DATA_WIDTH-1:0]                 ram_wd;
  logic                                  err_q;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    amc_port_decode #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_WORDS(MEM_WORDS)) u_dec (
      .addr     (addr_a[p]),
      .in_range (in_range[p])
    );
  end

  // ROM image is a fixed pattern rather than a loaded table
  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ 32'(a);
    return DATA_WIDTH'(w);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (BYPASS_BOOT != 0) ? RUNNING : BOOT_FETCH;
      boot_addr <= '0;
      rr        <= PW'(NUM_PORTS - 1);
    end else begin
      state <= state_n;
      if (state == BOOT_WRITE) boot_addr <= boot_addr + 1'b1;
      if (hs) rr <= grant;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      BOOT_FETCH: state_n = BOOT_WRITE;
      BOOT_WRITE: state_n = (boot_addr == BOOT_LAST) ? RUNNING : BOOT_FETCH;
      RUNNING:    state_n = RUNNING;
      ERROR:      state_n = ERROR;
      default:    state_n = ERROR;
    endcase
  end

  // Search starts one past the last winner, wrapping around
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PW'((int'(rr) + i) % NUM_PORTS);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  assign boot_done = (state == RUNNING);
  assign hs        = boot_done && grant_vld;
  assign req_ready = hs ? (NUM_PORTS'(1) << grant) : '0;

  assign g.write    = req_write[grant];
  assign g.in_range = in_range[grant];
  assign g.addr     = addr_a[grant];
  assign g.wdata    = wdata_a[grant];

  always_ff @(posedge clk) begin
    if (state == BOOT_FETCH) rom_q <= rom_word(boot_addr);
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = g.addr;
    ram_wd    = g.wdata;
    if (state == BOOT_WRITE) begin
      ram_we    = 1'b1;
      ram_waddr = boot_addr;
      ram_wd    = rom_q;
    end else if (hs && g.write && g.in_range) begin
      ram_we = 1'b1;
    end
    if (rst) ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wd;
  end

  // Read data register doubles as the held response bus
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q     <= '0;
      rsp_valid <= '0;
      rsp_error <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_error <= 1'b0;
      if (hs && !g.write) begin
        ram_q     <= g.in_range ? mem[g.addr] : '0;
        rsp_valid <= req_ready;
        rsp_error <= !g.in_range;
      end
      if ((hs && !g.in_range) || state == ERROR) err_q <= 1'b1;
    end
  end

  assign rsp_rdata    = ram_q;
  assign memory_error = err_q || (state == ERROR);

endmodule

// File: tb/tb_arbitrated_memory_controller.sv
// Randomized bench for the arbitrated memory controller with a cycle-level
// behavioural model plus directed literal checks for boot, contention and errors.

module tb_arbitrated_memory_controller;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int MW = 200;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          boot_done, memory_error, rsp_error;
  logic [N-1:0]  req_valid = '0, req_ready, req_write = '0, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  arbitrated_memory_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(N),
    .MEM_WORDS(MW), .BOOT_WORDS(BW), .BYPASS_BOOT(0)
  ) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done), .memory_error(memory_error),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: outputs expected right after the most recent clock edge
  bit            armed = 0;
  bit            m_run;
  int            m_boot_cnt;
  int            m_last;
  bit            m_err;
  logic [N-1:0]  m_rv;
  bit            m_re;
  logic [DW-1:0] m_rd;
  bit            m_rd_known;
  logic [DW-1:0] m_mem [256];
  bit            m_known [256];
  int            gp, pp, ma;
  logic [N-1:0]  er;

  always @(negedge clk) begin
    gp = -1;
    er = '0;
    if (m_run)
      for (int k = 1; k <= N; k++) begin
        pp = (m_last + k) % N;
        if (gp < 0 && req_valid[pp]) gp = pp;
      end
    if (gp >= 0) er[gp] = 1'b1;
    if (armed) begin
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("boot_done", 32'(boot_done), 32'(m_run));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_error", 32'(rsp_error), 32'(m_re));
      chk("memory_error", 32'(memory_error), 32'(m_err));
      if (m_rd_known) chk("rsp_rdata", rsp_rdata, m_rd);
    end
    if (rst) begin
      armed = 1; m_run = 0; m_boot_cnt = 0; m_last = N - 1; m_err = 0;
      m_rv = '0; m_re = 0; m_rd = '0; m_rd_known = 1;
    end else if (armed) begin
      m_rv = '0; m_re = 0;
      if (!m_run) begin
        m_boot_cnt++;
        if (m_boot_cnt == 2 * BW) begin
          m_run = 1;
          for (int i = 0; i < BW; i++) begin
            m_mem[i] = 32'hA5A5_0000 ^ i; m_known[i] = 1;
          end
        end
      end else if (gp >= 0) begin
        m_last = gp;
        ma = int'(req_addr[gp*AW +: AW]);
        if (ma >= MW) m_err = 1;
        if (req_write[gp]) begin
          if (ma < MW) begin m_mem[ma] = req_wdata[gp*DW +: DW]; m_known[ma] = 1; end
        end else begin
          m_rv[gp] = 1'b1;
          m_re = (ma >= MW);
          m_rd = (ma < MW) ? m_mem[ma] : '0;
          m_rd_known = (ma < MW) ? m_known[ma] : 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_port(input int p, input bit v, input bit w, input int a, input logic [DW-1:0] d);
    req_valid[p] = v;
    req_write[p] = w;
    req_addr[p*AW +: AW] = AW'(a);
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic idle();
    for (int p = 0; p < N; p++) set_port(p, 0, 0, 0, '0);
  endtask

  task automatic boot_wait(output int cnt);
    cnt = 0;
    while (!boot_done && cnt < 200) begin tick(); cnt++; end
  endtask

  initial begin
    int cnt;
    logic [DW-1:0] expd;
    for (int p = 0; p < N; p++) set_port(p, 1, 0, p + 1, '0);
    tick(); tick();
    chk("reset_boot_done", 32'(boot_done), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_memory_error", 32'(memory_error), 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;
    boot_wait(cnt);
    chk("boot_cycles", cnt, 2 * BW);

    // All three ports read addrs 1,2,3 from the first RUNNING cycle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("contention_grant", 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      chk("contention_rsp_valid", 32'(rsp_valid), 32'(1 << (k % 3)));
      expd = 32'hA5A5_0000 | (k % 3 + 1);
      chk("contention_rdata", rsp_rdata, expd);
    end

    idle();
    set_port(1, 1, 1, 5, 32'hDEAD_BEEF);
    tick();
    idle();
    set_port(0, 1, 0, 5, '0);
    tick();
    chk("wr_rd_valid", 32'(rsp_valid), 32'b001);
    chk("wr_rd_data", rsp_rdata, 32'hDEAD_BEEF);

    set_port(0, 1, 0, 250, '0);
    tick();
    chk("oor_valid", 32'(rsp_valid), 32'b001);
    chk("oor_error", 32'(rsp_error), 1);
    chk("oor_rdata", rsp_rdata, 0);
    chk("oor_sticky", 32'(memory_error), 1);
    set_port(0, 1, 0, 3, '0);
    tick();
    idle();
    chk("post_oor_error", 32'(rsp_error), 0);
    chk("post_oor_rdata", rsp_rdata, 32'hA5A5_0003);
    tick(); tick();
    chk("oor_still_sticky", 32'(memory_error), 1);

    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++)
        set_port(p, $urandom_range(0, 99) < 60, $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 3) != 0) ? $urandom_range(0, 31) : $urandom_range(190, 255),
                 $urandom());
      tick();
    end

    // Restart boot, then hit reset again part way through the copy
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      for (int p = 0; p < N; p++) set_port(p, 1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom());
      tick();
    end
    rst = 1'b1; tick();
    chk("midboot_boot_done", 32'(boot_done), 0);
    chk("midboot_memory_error", 32'(memory_error), 0);
    rst = 1'b0;
    for (int p = 0; p < N; p++) set_port(p, 1, 1, p, 32'h1234_5678);
    boot_wait(cnt);
    chk("reboot_cycles", cnt, 2 * BW);
    idle();
    set_port(0, 1, 0, 5, '0);
    tick();
    idle();
    chk("reboot_restored", rsp_rdata, 32'hA5A5_0005);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
